// File: rtl/voice_scheduler_if.sv
// ----------------------------------------------------------------------------
// voice_scheduler_if : scheduler <-> sequential voice generator handshake
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface voice_scheduler_if #(
  parameter int WAVE_W = 10
);
  logic              start_o;
  logic [1:0]        act_voice_o;
  logic [15:0]       freq_word_o;
  logic [11:0]       pw_word_o;
  logic [3:0]        wave_sel_o;
  logic              ready_i;
  logic [WAVE_W-1:0] wave_i;

  modport master (
    output start_o, act_voice_o, freq_word_o, pw_word_o, wave_sel_o,
    input  ready_i, wave_i
  );

  modport slave (
    input  start_o, act_voice_o, freq_word_o, pw_word_o, wave_sel_o,
    output ready_i, wave_i
  );
endinterface

`default_nettype wire

// File: rtl/voice_scheduler.sv
// ----------------------------------------------------------------------------
// voice_scheduler : walks all voices through the shared generator per tick
// and sums enabled voices into one mix. Optional watchdog: VOICE_SCHED_TIMEOUT_EN
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module voice_scheduler #(
  parameter int NUM_VOICES  = 3,
  parameter int WAVE_W      = 10,
  parameter int MIX_W       = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      sample_tick_i,
  input  logic [NUM_VOICES-1:0]     voice_en_i,
  input  logic [16*NUM_VOICES-1:0]  freq_words_i,
  input  logic [12*NUM_VOICES-1:0]  pw_words_i,
  input  logic [4*NUM_VOICES-1:0]   wave_sels_i,
  voice_scheduler_if.master         gen,
  output logic [MIX_W-1:0]          mix_o,
  output logic                      mix_valid_o,
  output logic                      busy_o,
  output logic                      overrun_o,
  output logic                      timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [MIX_W-1:0] acc_q, acc_d;
  logic [MIX_W-1:0] mix_q, mix_d;
  logic             mix_valid_q, mix_valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  logic             expired;
  logic             en_sel;
  logic [15:0]      freq_sel;
  logic [11:0]      pw_sel;
  logic [3:0]       wave_sel;
  logic [MIX_W-1:0] contrib;

  // The generator consumes the config combinationally, so it follows idx directly.
  always_comb begin
    freq_sel = freq_words_i[15:0];
    pw_sel   = pw_words_i[11:0];
    wave_sel = wave_sels_i[3:0];
    en_sel   = voice_en_i[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (idx_q == 2'(v)) begin
        freq_sel = freq_words_i[16*v +: 16];
        pw_sel   = pw_words_i[12*v +: 12];
        wave_sel = wave_sels_i[4*v +: 4];
        en_sel   = voice_en_i[v];
      end
    end
  end

`ifdef VOICE_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;

  // Counter is cleared outside WAIT, so each voice starts a fresh budget.
  always_comb begin
    wdog_d = '0;
    if (state_q == WAIT) wdog_d = wdog_q + 1'b1;
  end

  assign expired = (state_q == WAIT) && !gen.ready_i &&
                   (wdog_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`else
  assign expired = 1'b0;
`endif

  assign contrib = (gen.ready_i && en_sel) ? MIX_W'(gen.wave_i) : '0;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    overrun_d   = sample_tick_i && (state_q != IDLE);
    timeout_d   = expired;
    case (state_q)
      IDLE: begin
        if (sample_tick_i) begin
          idx_d   = 2'd0;
          acc_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (gen.ready_i || expired) begin
          if (idx_q == 2'(NUM_VOICES - 1)) begin
            mix_d       = acc_q + contrib;
            mix_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            acc_d   = acc_q + contrib;
            idx_d   = idx_q + 2'd1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      acc_q       <= '0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gen.start_o     = (state_q == ISSUE);
  assign gen.act_voice_o = idx_q;
  assign gen.freq_word_o = freq_sel;
  assign gen.pw_word_o   = pw_sel;
  assign gen.wave_sel_o  = wave_sel;
  assign mix_o           = mix_q;
  assign mix_valid_o     = mix_valid_q;
  assign busy_o          = (state_q != IDLE);
  assign overrun_o       = overrun_q;
  assign timeout_o       = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_voice_scheduler.sv
// ----------------------------------------------------------------------------
// tb_voice_scheduler : randomized bench; a per-cycle expectation schedule is
// planned from the handshake timing rules and compared against the DUT.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_voice_scheduler;
  localparam int NV   = 3;
  localparam int WW   = 10;
  localparam int MW   = 12;
  localparam int TO   = 16;
  localparam int MAXC = 8192;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              rst_ni;
  logic              sample_tick_i;
  logic [NV-1:0]     voice_en_i;
  logic [16*NV-1:0]  freq_words_i;
  logic [12*NV-1:0]  pw_words_i;
  logic [4*NV-1:0]   wave_sels_i;
  logic [MW-1:0]     mix_o;
  logic              mix_valid_o, busy_o, overrun_o, timeout_o;

  voice_scheduler_if #(.WAVE_W(WW)) gen_if ();

  voice_scheduler #(.NUM_VOICES(NV), .WAVE_W(WW), .MIX_W(MW), .TIMEOUT_CYC(TO)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sample_tick_i (sample_tick_i),
    .voice_en_i    (voice_en_i),
    .freq_words_i  (freq_words_i),
    .pw_words_i    (pw_words_i),
    .wave_sels_i   (wave_sels_i),
    .gen           (gen_if.master),
    .mix_o         (mix_o),
    .mix_valid_o   (mix_valid_o),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o),
    .timeout_o     (timeout_o)
  );

  // stimulus tables
  bit            t_tick [MAXC];
  bit            t_rst  [MAXC];
  bit            t_rdy  [MAXC];
  logic [WW-1:0] t_wave [MAXC];
  logic [NV-1:0] t_en   [MAXC];
  // expectation tables
  bit            e_busy [MAXC];
  bit            e_start[MAXC];
  bit            e_mixv [MAXC];
  bit            e_ovr  [MAXC];
  bit            e_to   [MAXC];
  bit            e_vchk [MAXC];
  int            e_voice[MAXC];
  int            e_mixval[MAXC];
  int            e_mix  [MAXC];

  int pd [NV];
  int pwv[NV];
  int p_en_force, p_silent, p_ovr, p_rst;
  bit p_ovr_at_r;

  int n_chk = 0, n_pass = 0;
  int cur = 0;
  bit run = 1'b0;
  int t0 = -100, t1 = -100, t2 = -100, t3 = -100, t5 = -100;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cur, act, exp);
  endtask

  function automatic bit live(input int c);
    return (p_rst == 0) || (c < p_rst);
  endfunction

  task automatic clear_p();
    p_en_force = -1; p_silent = -1; p_ovr = 0; p_ovr_at_r = 1'b0; p_rst = 0;
  endtask

  // One sample: voice v is issued at s, answered at s+pd[v], next voice at s+pd[v]+1.
  task automatic plan(input int t, output int endc);
    int s, r, acc;
    bit sil;
    t_tick[t] = 1'b1;
    s   = t + 1;
    acc = 0;
    for (int v = 0; v < NV; v++) begin
      sil = (v == p_silent);
`ifdef VOICE_SCHED_TIMEOUT_EN
      r = sil ? s + TO : s + pd[v];
`else
      r = sil ? s + 40 : s + pd[v];
`endif
      for (int c = s; c <= r; c++)
        if (live(c)) begin e_busy[c] = 1'b1; e_vchk[c] = 1'b1; e_voice[c] = v; end
      if (live(s)) e_start[s] = 1'b1;
      if (!sil) begin
        if (p_en_force >= 0) t_en[r] = NV'(p_en_force);
        if (live(r)) begin t_rdy[r] = 1'b1; t_wave[r] = WW'(pwv[v]); end
        if (t_en[r][v]) acc += pwv[v];
      end else begin
`ifdef VOICE_SCHED_TIMEOUT_EN
        if (live(r + 1)) e_to[r + 1] = 1'b1;
`endif
      end
      s = r + 1;
    end
    if (p_ovr_at_r) p_ovr = s - 1;
    if (p_ovr > 0 && live(p_ovr + 1)) begin t_tick[p_ovr] = 1'b1; e_ovr[p_ovr + 1] = 1'b1; end
    if (p_rst > 0) begin
      for (int c = p_rst; c <= p_rst + 1; c++) begin
        t_rst[c] = 1'b1; e_vchk[c] = 1'b1; e_voice[c] = 0;
      end
      endc = p_rst + 2;
    end else begin
      e_mixv[s] = 1'b1;
      e_mixval[s] = acc;
      endc = s;
    end
  endtask

  // Per-cycle compare against the planned schedule, plus literal pins.
  always @(negedge clk_i) begin
    if (run) begin
      chk("busy",      int'(busy_o),           int'(e_busy[cur]));
      chk("start",     int'(gen_if.start_o),   int'(e_start[cur]));
      chk("mix_valid", int'(mix_valid_o),      int'(e_mixv[cur]));
      chk("mix",       int'(mix_o),            e_mix[cur]);
      chk("overrun",   int'(overrun_o),        int'(e_ovr[cur]));
      chk("timeout",   int'(timeout_o),        int'(e_to[cur]));
      if (e_vchk[cur]) begin
        chk("act_voice", int'(gen_if.act_voice_o), e_voice[cur]);
        chk("freq",  int'(gen_if.freq_word_o), int'(freq_words_i[16*e_voice[cur] +: 16]));
        chk("pw",    int'(gen_if.pw_word_o),   int'(pw_words_i[12*e_voice[cur] +: 12]));
        chk("wsel",  int'(gen_if.wave_sel_o),  int'(wave_sels_i[4*e_voice[cur] +: 4]));
      end
      if (cur == t0 + 1 || cur == t0 + 5 || cur == t0 + 9) chk("pin_start", int'(gen_if.start_o), 1);
      if (cur == t0 + 13) chk("pin_mix600",  int'(mix_o), 600);
      if (cur == t0 + 13) chk("pin_mixv",    int'(mix_valid_o), 1);
      if (cur == t1 + 13) chk("pin_mix2046", int'(mix_o), 2046);
      if (cur == t2 + 13) chk("pin_mix3069", int'(mix_o), 3069);
      if (cur == t3 + 7)  chk("pin_overrun", int'(overrun_o), 1);
      if (cur == t5 + 6)  chk("pin_rst_busy", int'(busy_o), 0);
    end
  end

  initial begin
    int nxt, endc, t, gap, m, total, mixcur, s1;
    rst_ni = 1'b0; sample_tick_i = 1'b0; voice_en_i = '0;
    freq_words_i = '0; pw_words_i = '0; wave_sels_i = '0;
    gen_if.ready_i = 1'b0; gen_if.wave_i = '0;

    for (int c = 0; c < MAXC; c++) t_en[c] = NV'($urandom);
    for (int c = 0; c < 3; c++) begin t_rst[c] = 1'b1; e_vchk[c] = 1'b1; end
    nxt = 4;

    clear_p(); pd = '{3, 3, 3}; pwv = '{100, 200, 300}; p_en_force = 7;
    t0 = nxt; plan(t0, endc); nxt = endc + 2;
    clear_p(); pd = '{3, 3, 3}; pwv = '{1023, 1023, 1023}; p_en_force = 5;
    t1 = nxt; plan(t1, endc); nxt = endc + 2;
    clear_p(); pd = '{3, 3, 3}; pwv = '{1023, 1023, 1023}; p_en_force = 7;
    t2 = nxt; plan(t2, endc); nxt = endc;
    clear_p(); pd = '{3, 3, 3}; pwv = '{5, 6, 7}; p_ovr = nxt + 6;
    t3 = nxt; plan(t3, endc); nxt = endc + 1;
    clear_p(); pd = '{3, 3, 3}; pwv = '{11, 22, 33}; p_ovr_at_r = 1'b1;
    plan(nxt, endc); nxt = endc + 1;
    clear_p(); pd = '{3, 3, 3}; pwv = '{44, 55, 66}; p_rst = nxt + 6;
    t5 = nxt; plan(t5, endc); nxt = endc;

    for (int k = 0; k < 150; k++) begin
      clear_p();
      for (int v = 0; v < NV; v++) begin
        pd[v]  = int'($urandom_range(1, 5));
        pwv[v] = int'($urandom_range(0, 1023));
      end
      gap = int'($urandom_range(0, 3));
      t = nxt + gap;
      for (int c = nxt; c <= t; c++)
        if ($urandom_range(0, 2) == 0) begin t_rdy[c] = 1'b1; t_wave[c] = WW'($urandom); end
      m = int'($urandom_range(0, 3));
      if (m == 1) p_ovr = t + int'($urandom_range(1, 6));
      if (m == 2) p_ovr_at_r = 1'b1;
      if ($urandom_range(0, 11) == 0) p_rst = t + int'($urandom_range(1, 6));
      plan(t, endc);
      nxt = endc;
    end

    clear_p();
    for (int v = 0; v < NV; v++) begin pd[v] = 2; pwv[v] = int'($urandom_range(0, 1023)); end
    p_silent = 1; p_en_force = 7;
`ifndef VOICE_SCHED_TIMEOUT_EN
    s1 = nxt + 2 + pd[0] + 1;
    p_rst = s1 + 41;
`else
    s1 = 0;
`endif
    plan(nxt + 1, endc);
    total = endc + 5;

    mixcur = 0;
    for (int c = 0; c < total; c++) begin
      if (t_rst[c]) mixcur = 0;
      else if (e_mixv[c]) mixcur = e_mixval[c];
      e_mix[c] = mixcur;
    end

    for (int c = 0; c < total; c++) begin
      @(posedge clk_i);
      #1;
      cur = c;
      rst_ni        = !t_rst[c];
      sample_tick_i = t_tick[c];
      voice_en_i    = t_en[c];
      gen_if.ready_i = t_rdy[c];
      gen_if.wave_i  = t_rdy[c] ? t_wave[c] : WW'($urandom);
      for (int v = 0; v < NV; v++) begin
        freq_words_i[16*v +: 16] = 16'($urandom);
        pw_words_i[12*v +: 12]   = 12'($urandom);
        wave_sels_i[4*v +: 4]    = 4'($urandom);
      end
      run = 1'b1;
    end
    @(posedge clk_i);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/voice_scheduler.md
# voice_scheduler

Initiator side of the voice-generator handshake. On every sample tick it walks voices 0..NUM_VOICES-1 through the shared sequential voice generator. For each voice it presents that voice's frequency, pulse-width and waveform configuration, pulses start, waits for ready and captures the returned waveform. It sums the enabled voices into one unsigned mix sample for the downstream filter/DAC path.

## Interface
Parameters:
- NUM_VOICES, 3, voices serviced per sample (1..4; act_voice_o is 2 bits)
- WAVE_W, 10, width of generator waveform
- MIX_W, 12, mix width; must be ≥ WAVE_W + clog2(NUM_VOICES)
- TIMEOUT_CYC, 16, WAIT-state watchdog limit (used only with VOICE_SCHED_TIMEOUT_EN)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous, active-low reset
- sample_tick_i  in  1  one-cycle pulse at sample rate
- voice_en_i  in  NUM_VOICES  bit v = 1 adds voice v to the mix
- freq_words_i  in  16*NUM_VOICES  voice v at [16v+15:16v]
- pw_words_i  in  12*NUM_VOICES  voice v at [12v+11:12v]
- wave_sels_i  in  4*NUM_VOICES  voice v at [4v+3:4v]
- start_o  out  1  one-cycle start pulse to generator
- act_voice_o  out  2  voice index presented to generator
- freq_word_o  out  16  config of act_voice_o (combinational mux)
- pw_word_o  out  12  config of act_voice_o
- wave_sel_o  out  4  config of act_voice_o
- ready_i  in  1  generator done; wave_i valid this cycle
- wave_i  in  WAVE_W  generator waveform
- mix_o  out  MIX_W  last completed mix (registered, held)
- mix_valid_o  out  1  one-cycle pulse when mix_o updates
- busy_o  out  1  high when state ≠ IDLE
- overrun_o  out  1  one-cycle pulse: tick arrived while busy
- timeout_o  out  1  one-cycle pulse: watchdog fired (tied 0 without macro)

## Operation
- States: IDLE, ISSUE, WAIT. Registers: state, voice index idx, accumulator acc (MIX_W), mix_o, mix_valid_o, overrun_o, timeout_o, watchdog counter.
- IDLE: on sample_tick_i → idx=0, acc=0, go ISSUE.
- ISSUE: start_o=1 for this single cycle → WAIT.
- WAIT: ready_i=1 → add zero-extended wave_i to acc if voice_en_i[idx], else add 0.
  - If idx < NUM_VOICES-1 → idx+1, go ISSUE.
  - If idx is the last voice → mix_o ≤ acc + contribution, mix_valid_o=1 next cycle, go IDLE.
- act_voice_o = idx. The config outputs mux from idx and stay stable from ISSUE until the cycle after ready_i, because the generator uses them combinationally.
- Every voice is issued each sample regardless of voice_en_i, so oscillator phases keep running. voice_en_i is sampled in the ready_i cycle.
- Arithmetic is unsigned and cannot overflow when the MIX_W rule holds. With the defaults, max mix = 3069.
- ready_i outside WAIT is ignored.
- sample_tick_i while busy_o=1 is dropped, and overrun_o pulses the next cycle. This includes a tick in the same cycle as the final ready_i. The current sample completes normally.

## Timing
- Reset values: state IDLE, idx 0, start_o 0, act_voice_o 0, mix_o 0, mix_valid_o 0, busy_o 0, overrun_o 0, timeout_o 0. The config outputs then show voice 0.
- Reset is asynchronous and may arrive mid-sample. The sample is abandoned, no mix_valid_o is produced, and mix_o returns to 0.
- Per voice: 1 ISSUE cycle plus the WAIT cycles up to and including the ready_i cycle.
- With a generator whose ready arrives 3 cycles after start (cycles c0..c3):
  - tick sampled in cycle T → start_o in T+1, T+5, T+9
  - ready_i in T+4, T+8, T+12
  - mix_valid_o in T+13
- The earliest accepted next tick is the mix_valid_o cycle (state is IDLE by then).
- mix_o holds its value until the next mix_valid_o.

## Configuration
- VOICE_SCHED_TIMEOUT_EN defined:
  - The watchdog counts WAIT cycles and resets on entering WAIT.
  - If TIMEOUT_CYC cycles pass without ready_i, the voice contributes 0 and timeout_o pulses for one cycle.
  - Sequencing then continues exactly as if ready_i had arrived.
- Not defined: no counter, timeout_o tied 0, WAIT lasts until ready_i.

## Test plan
- Defaults, responder model with 3-cycle ready. Tick; all voices enabled; responder returns wave 100, 200, 300 → start_o in T+1/T+5/T+9, act_voice_o 0,1,2 with matching freq/pw/wave_sel, mix_o=600, mix_valid_o single pulse at T+13.
- voice_en_i=3'b101, waves 1023/1023/1023 → mix_o=2046. All three start_o pulses are still issued.
- All enabled, waves 1023 each → mix_o=3069, no wrap.
- Second tick at T+6 → overrun_o pulses at T+7; only one mix_valid_o is produced, at T+13. A tick in the same cycle as the final ready_i also produces overrun_o.
- rst_ni low at T+6 → all outputs return to reset values immediately; no mix_valid_o; the next tick restarts at voice 0.
- With VOICE_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, responder silent for voice 1 → timeout_o pulses once, voice 1 contributes 0, voice 2 is issued next, mix_o = wave0 + wave2. Without the macro, busy_o stays high indefinitely.
